uart_word_rx: RTL
=================

UART_WORD_RX -- requirements
Module: uart_word_rx

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Parameter DELAY_FRAMES SHALL be provided: default 234; clocks per UART bit (27 MHz / 115200 baud); legal range 8..65535.
REQ-003 Parameter WORD_TIMEOUT SHALL be provided: default 23400; max idle clocks between bytes of one word before the partial word is discarded.
REQ-004 The block SHALL provide port clk, input, 1: system clock; all state updates on its rising edge.
REQ-005 The block SHALL provide port reset, input, 1: asynchronous, active-high reset.
REQ-006 The block SHALL provide port uart_rx, input, 1: serial line; idle high, asynchronous to clk.
REQ-007 The block SHALL provide port byte_data, output, 8: last correctly framed byte.
REQ-008 The block SHALL provide port byte_valid, output, 1: one-clock pulse when byte_data updates.
REQ-009 The block SHALL provide port word_data, output, 32: last assembled word; first received byte in [31:24].
REQ-010 The block SHALL provide port word_valid, output, 1: one-clock pulse when word_data updates.
REQ-011 The block SHALL provide port frame_error, output, 1: one-clock pulse on a bad stop bit.

Function
REQ-012 uart_rx SHALL pass through a 2-flop synchronizer initialised to 1; all decisions use the synchronized bit (rx_s); input-to-rx_s latency is 2 clocks.
REQ-013 The FSM SHALL have the states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-014 IDLE: on rx_s==0, go to START with the bit counter cleared.
REQ-015 START: count to DELAY_FRAMES/2 (integer division); at that count, if rx_s==0 go to DATA with the counter and bit index cleared, else (false start) return to IDLE with no output.
REQ-016 DATA: sample rx_s when the counter reaches DELAY_FRAMES-1 and clear the counter; bits are LSB first, 8 bits; after bit 7 go to STOP.
REQ-017 STOP: sample at DELAY_FRAMES-1; if rx_s==1, load byte_data, pulse byte_valid on the next clock and go to IDLE.
REQ-018 STOP with rx_s==0: pulse frame_error, leave byte_data unchanged, discard any partial word, and go to WAIT_HIGH.
REQ-019 WAIT_HIGH: remain until rx_s==1, then go to IDLE; a held-low break line SHALL produce exactly one frame_error.
REQ-020 Word assembly: on each good byte, shift it into a 32-bit accumulator as {acc[23:0], byte} and increment a 2-bit byte count.
REQ-021 When the 4th byte arrives (count==3), load word_data from the accumulator, pulse word_valid in the same cycle as that byte's byte_valid, and wrap the count to 0.
REQ-022 Timeout counter: cleared on every good byte; increments only while the byte count is nonzero and the FSM is in IDLE; on reaching WORD_TIMEOUT, reset the byte count to 0; word_data is not modified; no pulse is generated.
REQ-023 A new start bit detected in the same cycle as a timeout SHALL proceed normally; the incoming byte becomes byte 0 of a new word.
REQ-024 byte_valid, word_valid and frame_error SHALL never be asserted for more than one consecutive clock.
REQ-025 Counters SHALL be wide enough for max(DELAY_FRAMES, WORD_TIMEOUT) and SHALL never wrap during normal operation.

Reset
REQ-026 While reset is high, the FSM SHALL be in IDLE; all counters and the accumulator SHALL be 0; the synchronizer flops SHALL be 1; byte_data=0x00, word_data=0x00000000 and byte_valid=word_valid=frame_error=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame without any output pulse; after release, reception restarts at the next falling edge of rx_s.

Verification (DELAY_FRAMES=16, WORD_TIMEOUT=400 unless noted)
REQ-028 Single byte: send 0xA5 with 16-clock bits -> exactly one byte_valid with byte_data=0xA5; no word_valid; no frame_error.
REQ-029 Word: send 0xDE, 0xAD, 0xBE, 0xEF back-to-back -> 4 byte_valid pulses; word_valid coincident with the 4th pulse; word_data=0xDEADBEEF.
REQ-030 Glitch and break: a 5-clock low pulse produces no output and returns the FSM to IDLE; a 0x55 frame with stop bit 0 gives one frame_error and no byte_valid. Holding the line low for 200 clocks also gives one frame_error and no further pulses; the next good byte is received correctly.
REQ-031 Timeout: send 0x11, 0x22, then idle 500 clocks, then 0x33, 0x44, 0x55, 0x66 -> exactly one word_valid, with word_data=0x33445566.
REQ-032 Reset mid-operation: assert reset during bit 4 of the 2nd byte of a word -> no pulses and outputs zeroed; after release, sending 0x01, 0x02, 0x03, 0x04 gives word_data=0x01020304.
REQ-033 Default parameters: send 0xC3 at 234 clocks/bit, with each bit edge skewed by +/-50 clocks -> byte_data=0xC3.

Source files
------------

// File: rtl/uart_word_rx.sv
// UART receiver (8N1) that also packs four consecutive good bytes into a 32-bit word.
// Latency: byte_valid/word_valid follow the stop-bit sample point by one clock; rx_s trails uart_rx by two clocks.
// No backpressure: the output pulses are single-cycle and are not held; a partial word is dropped after an idle timeout.
module uart_word_rx #(
  parameter int DELAY_FRAMES = 234,
  parameter int WORD_TIMEOUT = 23400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rx,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic [31:0] word_data,
  output logic        word_valid,
  output logic        frame_error
);

  localparam int MAXC = (DELAY_FRAMES > WORD_TIMEOUT) ? DELAY_FRAMES : WORD_TIMEOUT;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] HALF_C     = CW'(DELAY_FRAMES / 2);
  localparam logic [CW-1:0] LAST_C     = CW'(DELAY_FRAMES - 1);
  localparam logic [CW-1:0] TMO_LAST_C = CW'(WORD_TIMEOUT - 1);
  localparam logic [CW-1:0] ONE_C      = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  logic [1:0]    sync_q;
  logic          rx_s;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_good;
  logic          bad_stop;

  logic [7:0]    byte_data_q;
  logic          byte_valid_q;
  logic [31:0]   word_data_q;
  logic          word_valid_q;
  logic          frame_error_q;
  logic [31:0]   acc_q;
  logic [1:0]    byte_cnt_q;
  logic [CW-1:0] tmo_q;

  assign rx_s = sync_q[1];

  // Two-flop synchronizer for the asynchronous serial line, idling high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], uart_rx};
  end

  // Receiver state, bit timer, bit index and data shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  // Next-state logic: mid-bit sampling, false-start rejection, stop-bit check.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_good = 1'b0;
    bad_stop  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_C) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      S_DATA: begin
        if (cnt_q == LAST_C) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      S_STOP: begin
        if (cnt_q == LAST_C) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_good = 1'b1;
            state_d   = S_IDLE;
          end else begin
            bad_stop = 1'b1;
            state_d  = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      S_WAIT_HIGH: begin
        // A break holds the line low; stay here so it reports only once.
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output pulses, word accumulator and inter-byte idle timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_data_q   <= '0;
      byte_valid_q  <= 1'b0;
      word_data_q   <= '0;
      word_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      acc_q         <= '0;
      byte_cnt_q    <= '0;
      tmo_q         <= '0;
    end else begin
      byte_valid_q  <= byte_good;
      frame_error_q <= bad_stop;
      word_valid_q  <= 1'b0;
      if (byte_good) begin
        byte_data_q <= shift_q;
        acc_q       <= {acc_q[23:0], shift_q};
        byte_cnt_q  <= byte_cnt_q + 2'd1;
        tmo_q       <= '0;
        if (byte_cnt_q == 2'd3) begin
          word_data_q  <= {acc_q[23:0], shift_q};
          word_valid_q <= 1'b1;
        end
      end else if (bad_stop) begin
        byte_cnt_q <= '0;
        tmo_q      <= '0;
      end else if (byte_cnt_q == 2'd0) begin
        tmo_q <= '0;
      end else if (state_q == S_IDLE) begin
        // A partial word that sits idle too long is silently dropped.
        if (tmo_q == TMO_LAST_C) begin
          byte_cnt_q <= '0;
          tmo_q      <= '0;
        end else begin
          tmo_q <= tmo_q + ONE_C;
        end
      end
    end
  end

  assign byte_data   = byte_data_q;
  assign byte_valid  = byte_valid_q;
  assign word_data   = word_data_q;
  assign word_valid  = word_valid_q;
  assign frame_error = frame_error_q;

endmodule
